hue_sequencer: RTL and testbench

Sequencer and PWM engine for the on-board RGB LED. It walks the three channels continuously around a six-segment hue wheel. A single shared period counter drives three duty comparators, and duty values update only on PWM period boundaries. It sits directly under top and drives the active-low RGB_R/RGB_G/RGB_B pins.

---
 rtl/hue_sequencer.sv | 179 +++++++++++++++++
 tb/tb_hue_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hue_sequencer.sv
// RGB LED hue-wheel sequencer: one shared PWM counter, three duty comparators, boundary-only duty updates.
// Optional build macro HUE_SEQ_GAMMA_EN squares each loaded duty (lin*lin/PWM_INTERVAL) for perceptual gamma.
module hue_sequencer #(
    parameter int PWM_INTERVAL      = 1200,
    parameter int STEPS_PER_SEGMENT = 64,
    parameter int PERIODS_PER_STEP  = 4,
    localparam int DW = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          jump_valid,
    input  logic [2:0]    jump_seg,
    output logic          jump_busy,
    output logic [2:0]    segment,
    output logic          wrap,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic          RGB_R,
    output logic          RGB_G,
    output logic          RGB_B
);
    localparam int SZ = PWM_INTERVAL / STEPS_PER_SEGMENT;
    localparam int SW = (STEPS_PER_SEGMENT > 1) ? $clog2(STEPS_PER_SEGMENT) : 1;
    localparam int PW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] CNT_LAST  = DW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] SZ_W      = DW'(SZ);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_SEGMENT - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIODS_PER_STEP - 1);

    if (PWM_INTERVAL % STEPS_PER_SEGMENT != 0) begin : g_bad_steps
        $error("PWM_INTERVAL must be a multiple of STEPS_PER_SEGMENT");
    end
    if (PERIODS_PER_STEP < 1) begin : g_bad_periods
        $error("PERIODS_PER_STEP must be at least 1");
    end

    logic [DW-1:0] r_pwm_cnt;
    logic [PW-1:0] r_period_cnt;
    logic [SW-1:0] r_step;
    logic [2:0]    r_segment;
    logic          r_wrap;
    logic          r_busy;
    logic [2:0]    r_pend_seg;

    logic          w_boundary;
    logic [2:0]    w_jump_tgt;
    logic [PW-1:0] w_period_next;
    logic [SW-1:0] w_step_next;
    logic [2:0]    w_seg_next;
    logic          w_wrap_next;
    logic [DW-1:0] w_up;
    logic [DW-1:0] w_down;
    logic [DW-1:0] w_lin  [3];
    logic [DW-1:0] w_duty [3];
    logic [2:0]    w_on;

    assign w_boundary = (r_pwm_cnt == CNT_LAST);
    assign w_jump_tgt = (jump_seg > 3'd5) ? 3'd0 : jump_seg;

    // A pending jump takes priority over the natural advance at the same boundary.
    always_comb begin
        w_period_next = r_period_cnt;
        w_step_next   = r_step;
        w_seg_next    = r_segment;
        w_wrap_next   = 1'b0;
        if (w_boundary) begin
            if (r_busy) begin
                w_seg_next    = r_pend_seg;
                w_step_next   = '0;
                w_period_next = '0;
            end else if (run) begin
                if (r_period_cnt == PER_LAST) begin
                    w_period_next = '0;
                    if (r_step == STEP_LAST) begin
                        w_step_next = '0;
                        if (r_segment == 3'd5) begin
                            w_seg_next  = 3'd0;
                            w_wrap_next = 1'b1;
                        end else begin
                            w_seg_next = r_segment + 3'd1;
                        end
                    end else begin
                        w_step_next = r_step + SW'(1);
                    end
                end else begin
                    w_period_next = r_period_cnt + PW'(1);
                end
            end
        end
    end

    // Table lookup is driven by the post-boundary position so new duties match the new step.
    always_comb begin
        w_up   = DW'(w_step_next) * SZ_W;
        w_down = FULL - w_up;
        w_lin[0] = FULL;
        w_lin[1] = '0;
        w_lin[2] = '0;
        case (w_seg_next)
            3'd0: begin w_lin[0] = FULL;   w_lin[1] = w_up;   w_lin[2] = '0;     end
            3'd1: begin w_lin[0] = w_down; w_lin[1] = FULL;   w_lin[2] = '0;     end
            3'd2: begin w_lin[0] = '0;     w_lin[1] = FULL;   w_lin[2] = w_up;   end
            3'd3: begin w_lin[0] = '0;     w_lin[1] = w_down; w_lin[2] = FULL;   end
            3'd4: begin w_lin[0] = w_up;   w_lin[1] = '0;     w_lin[2] = FULL;   end
            default: begin w_lin[0] = FULL; w_lin[1] = '0;    w_lin[2] = w_down; end
        endcase
    end

`ifdef HUE_SEQ_GAMMA_EN
    function automatic logic [DW-1:0] f_gamma(input logic [DW-1:0] lin);
        logic [2*DW-1:0] sq;
        sq = {{DW{1'b0}}, lin} * {{DW{1'b0}}, lin};
        return DW'(sq / (2*DW)'(PWM_INTERVAL));
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt    <= '0;
            r_period_cnt <= '0;
            r_step       <= '0;
            r_segment    <= 3'd0;
            r_wrap       <= 1'b0;
            r_busy       <= 1'b0;
            r_pend_seg   <= 3'd0;
        end else begin
            r_pwm_cnt    <= w_boundary ? '0 : r_pwm_cnt + DW'(1);
            r_period_cnt <= w_period_next;
            r_step       <= w_step_next;
            r_segment    <= w_seg_next;
            r_wrap       <= w_wrap_next;
            // A request landing on the boundary cycle is held for the following boundary.
            if (jump_valid) begin
                r_busy     <= 1'b1;
                r_pend_seg <= w_jump_tgt;
            end else if (w_boundary) begin
                r_busy <= 1'b0;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_ch
        logic [DW-1:0] w_load;
        logic [DW-1:0] r_duty;
        logic          r_on;
`ifdef HUE_SEQ_GAMMA_EN
        assign w_load = f_gamma(w_lin[gi]);
`else
        assign w_load = w_lin[gi];
`endif
        always_ff @(posedge clk) begin
            if (rst) begin
                r_duty <= (gi == 0) ? FULL : '0;
                r_on   <= 1'b0;
            end else begin
                if (w_boundary) begin
                    r_duty <= w_load;
                end
                r_on <= (r_pwm_cnt < r_duty);
            end
        end
        assign w_duty[gi] = r_duty;
        assign w_on[gi]   = r_on;
    end

    assign jump_busy = r_busy;
    assign segment   = r_segment;
    assign wrap      = r_wrap;
    assign duty_r    = w_duty[0];
    assign duty_g    = w_duty[1];
    assign duty_b    = w_duty[2];
    assign RGB_R     = ~w_on[0];
    assign RGB_G     = ~w_on[1];
    assign RGB_B     = ~w_on[2];
endmodule

// File: tb/tb_hue_sequencer.sv
// Bench for hue_sequencer: directed scenarios plus random run/jump/reset traffic against a wheel-position model.
module tb_hue_sequencer;
    localparam int PI  = 8;
    localparam int SPS = 4;
    localparam int PPS = 2;
    localparam int DW  = $clog2(PI + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          jump_valid = 1'b0;
    logic [2:0]    jump_seg = 3'd0;
    logic          jump_busy;
    logic [2:0]    segment;
    logic          wrap;
    logic [DW-1:0] duty_r, duty_g, duty_b;
    logic          RGB_R, RGB_G, RGB_B;

    always #5 clk = ~clk;

    hue_sequencer #(
        .PWM_INTERVAL     (PI),
        .STEPS_PER_SEGMENT(SPS),
        .PERIODS_PER_STEP (PPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .jump_valid(jump_valid),
        .jump_seg  (jump_seg),
        .jump_busy (jump_busy),
        .segment   (segment),
        .wrap      (wrap),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .RGB_R     (RGB_R),
        .RGB_G     (RGB_G),
        .RGB_B     (RGB_B)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_wrap  = 0;

    // Model state: wheel position pos = segment*SPS + step, 0 .. 6*SPS-1.
    int m_cnt, m_per, m_pos, m_pend;
    bit m_busy, m_wrap;
    int m_duty [3];
    bit m_on   [3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Red's level around the wheel; green and blue are the same curve rotated by 2 and 4 segments.
    function automatic int base_lvl(input int s, input int up);
        case (s)
            0, 5:    return PI;
            1:       return PI - up;
            4:       return up;
            default: return 0;
        endcase
    endfunction

    function automatic int chan(input int pos, input int ch);
        int s, up, sh, v;
        s  = pos / SPS;
        up = (pos % SPS) * (PI / SPS);
        sh = (ch == 0) ? 0 : ((ch == 1) ? 4 : 2);
        v  = base_lvl((s + sh) % 6, up);
`ifdef HUE_SEQ_GAMMA_EN
        v = (v * v) / PI;
`endif
        return v;
    endfunction

    task automatic model_step();
        bit bnd;
        if (rst) begin
            m_cnt = 0; m_per = 0; m_pos = 0; m_pend = 0;
            m_busy = 0; m_wrap = 0;
            for (int i = 0; i < 3; i++) begin
                m_duty[i] = chan(0, i);
                m_on[i]   = 0;
            end
        end else begin
            bnd = (m_cnt == PI - 1);
            for (int i = 0; i < 3; i++) m_on[i] = (m_cnt < m_duty[i]);
            m_wrap = 0;
            if (bnd) begin
                if (m_busy) begin
                    m_pos = m_pend * SPS;
                    m_per = 0;
                end else if (run) begin
                    m_per++;
                    if (m_per == PPS) begin
                        m_per = 0;
                        m_pos++;
                        if (m_pos == 6 * SPS) begin
                            m_pos  = 0;
                            m_wrap = 1;
                        end
                    end
                end
                for (int i = 0; i < 3; i++) m_duty[i] = chan(m_pos, i);
            end
            if (jump_valid) begin
                m_busy = 1;
                m_pend = (jump_seg > 5) ? 0 : int'(jump_seg);
            end else if (bnd) begin
                m_busy = 0;
            end
            m_cnt = (m_cnt + 1) % PI;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (wrap === 1'b1) n_wrap++;
        check("segment", segment, m_pos / SPS);
        check("duty_r", duty_r, m_duty[0]);
        check("duty_g", duty_g, m_duty[1]);
        check("duty_b", duty_b, m_duty[2]);
        check("rgb_r", RGB_R, !m_on[0]);
        check("rgb_g", RGB_G, !m_on[1]);
        check("rgb_b", RGB_B, !m_on[2]);
        check("wrap", wrap, m_wrap);
        check("jump_busy", jump_busy, m_busy);
    endtask

    initial begin
        // Reset, then idle with run low: red solid, others dark.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0; run = 1'b0;
        repeat (24) tick();
        check("idle_rgb_r", RGB_R, 0);
        check("idle_seg", segment, 0);
        check("idle_duty_r", duty_r, PI);

        // Full wheel from reset: exactly one wrap pulse.
        rst = 1'b1; tick();
        rst = 1'b0; run = 1'b1; n_wrap = 0;
        repeat (390) tick();
        check("wrap_once", n_wrap, 1);
        check("wheel_seg", segment, 0);
        check("wheel_duty_r", duty_r, PI);
        check("wheel_duty_g", duty_g, 0);

        // Jump to segment 3 while stopped.
        run = 1'b0;
        for (int k = 0; k < 50 && m_cnt != 2; k++) tick();
        check("wait_j3", m_cnt, 2);
        jump_valid = 1'b1; jump_seg = 3'd3; tick();
        jump_valid = 1'b0;
        check("j3_busy", jump_busy, 1);
        for (int k = 0; k < 50 && m_cnt != 0; k++) tick();
        check("j3_seg", segment, 3);
        check("j3_duty_r", duty_r, 0);
        check("j3_duty_g", duty_g, PI);
        check("j3_duty_b", duty_b, PI);
        check("j3_busy_clr", jump_busy, 0);

        // Two jumps in one period: the later (7 -> 0) wins.
        for (int k = 0; k < 50 && m_cnt != 1; k++) tick();
        jump_valid = 1'b1; jump_seg = 3'd2; tick();
        jump_valid = 1'b0; tick();
        jump_valid = 1'b1; jump_seg = 3'd7; tick();
        jump_valid = 1'b0;
        for (int k = 0; k < 50 && m_cnt != 0; k++) tick();
        check("j2j7_seg", segment, 0);

        // Jump coinciding with the natural 5->0 advance.
        run = 1'b1;
        for (int k = 0; k < 2000 && !(m_pos == 6*SPS-1 && m_per == PPS-1 && m_cnt == 3); k++) tick();
        check("wait_coinc", m_pos, 6*SPS-1);
        jump_valid = 1'b1; jump_seg = 3'd2; tick();
        jump_valid = 1'b0;
        for (int k = 0; k < 50 && m_cnt != 0; k++) tick();
        check("coinc_seg", segment, 2);
        check("coinc_wrap", wrap, 0);

        // Reset mid segment 4 with a jump pending.
        for (int k = 0; k < 2000 && !(m_pos == 4*SPS+1 && m_cnt == 1); k++) tick();
        check("wait_seg4", segment, 4);
        jump_valid = 1'b1; jump_seg = 3'd1; tick();
        jump_valid = 1'b0;
        check("rst_pend_busy", jump_busy, 1);
        rst = 1'b1; tick();
        rst = 1'b0;
        check("rst_busy", jump_busy, 0);
        check("rst_seg", segment, 0);
        check("rst_duty_r", duty_r, PI);
        check("rst_rgb_g", RGB_G, 1);
        repeat (20) tick();
        check("rst_nojump_seg", segment, 0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 499) == 0);
            run        = ($urandom_range(0, 9) != 0);
            jump_valid = ($urandom_range(0, 19) == 0);
            jump_seg   = 3'($urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
